// File: rtl/detect_sequence_pkg.sv
// rtl/detect_sequence_pkg.sv - shared state encoding and pattern constant for the 0110 detector
package detect_sequence_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] PATTERN = 4'b0110;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S01  = 3'd2,
    S011 = 3'd3,
    DET  = 3'd4
  } state_e;

endpackage

// File: rtl/detect_sequence_0110.sv
// rtl/detect_sequence_0110.sv - Moore detector for serial 0110 with registered match pulse
// Optional saturating match counter enabled by DETECT_SEQUENCE_COUNT_EN.
module detect_sequence_0110
  import detect_sequence_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
`ifdef DETECT_SEQUENCE_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             out
);

  if (CNT_W < 1) begin : g_cnt_w_invalid
    $error("detect_sequence_0110: CNT_W must be at least 1");
  end

  state_e state_q, state_d;
  logic   out_q, out_d;
  logic   bit_one;

  // Anything other than a clean 1 is treated as 0.
  assign bit_one = (in == 1'b1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bit_one ? IDLE : S0;
      S0:      state_d = bit_one ? S01  : S0;
      S01:     state_d = bit_one ? S011 : S0;
      S011:    state_d = bit_one ? IDLE : DET;
      DET: begin
        if (!bit_one)          state_d = S0;
        else if (OVERLAP != 0) state_d = S01;
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_d = (state_d == DET);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

`ifdef DETECT_SEQUENCE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts on the edge that enters DET, holding at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (out_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_detect_sequence_0110.sv
// tb/tb_detect_sequence_0110.sv - randomized and directed bench for detect_sequence_0110 against a history-window model
module tb_detect_sequence_0110;
  import detect_sequence_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in = 1'b0;
  logic out_ov, out_no, out_sat;

  int checks = 0;
  int failures = 0;

  localparam int N = 3;
  int          ovl[N]  = '{1, 0, 1};
  int          cmax[N] = '{255, 255, 3};
  logic [3:0]  hist[N];
  int          nvalid[N];
  int          mcnt[N];
  logic        exp_out[N];

  always #5 clk = ~clk;

`ifdef DETECT_SEQUENCE_COUNT_EN
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;

  detect_sequence_0110 #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .in(in), .match_cnt(cnt_ov), .out(out_ov));
  detect_sequence_0110 #(.OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .in(in), .match_cnt(cnt_no), .out(out_no));
  detect_sequence_0110 #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in(in), .match_cnt(cnt_sat), .out(out_sat));
`else
  detect_sequence_0110 #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .in(in), .out(out_ov));
  detect_sequence_0110 #(.OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .in(in), .out(out_no));
  detect_sequence_0110 #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in(in), .out(out_sat));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // A match is the last four accepted bits equal to the pattern; without overlap,
  // bits consumed by a match are forgotten.
  task automatic model_step(input logic b, input logic r);
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        hist[i] = 4'b0; nvalid[i] = 0; mcnt[i] = 0; exp_out[i] = 1'b0;
      end else begin
        hist[i] = {hist[i][2:0], b};
        nvalid[i]++;
        exp_out[i] = (nvalid[i] >= 4) && (hist[i] == PATTERN);
        if (exp_out[i]) begin
          if (mcnt[i] < cmax[i]) mcnt[i]++;
          if (ovl[i] == 0) nvalid[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic b, input logic r, input string tag);
    @(negedge clk);
    in = b;
    reset = r;
    @(posedge clk);
    #1;
    model_step(b, r);
    check({tag, ":out_ov"},  {31'b0, out_ov},  {31'b0, exp_out[0]});
    check({tag, ":out_no"},  {31'b0, out_no},  {31'b0, exp_out[1]});
    check({tag, ":out_sat"}, {31'b0, out_sat}, {31'b0, exp_out[2]});
`ifdef DETECT_SEQUENCE_COUNT_EN
    check({tag, ":cnt_ov"},  {24'b0, cnt_ov},  mcnt[0]);
    check({tag, ":cnt_no"},  {24'b0, cnt_no},  mcnt[1]);
    check({tag, ":cnt_sat"}, {30'b0, cnt_sat}, mcnt[2]);
`endif
  endtask

  task automatic send(input logic [31:0] bits, input int n, input string tag);
    for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1, tag);
  endtask

  int pulses_ov;
  int pulses_no;

  initial begin
    for (int i = 0; i < N; i++) begin
      hist[i] = 4'b0; nvalid[i] = 0; mcnt[i] = 0; exp_out[i] = 1'b0;
    end

    // reset held two cycles with in toggling
    step(1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, "reset");
    check("reset_out", {31'b0, out_ov}, 32'd0);

    send(32'b0110, 4, "basic");
    check("basic_pulse", {31'b0, out_ov}, 32'd1);

    step(1'b0, 1'b0, "rst2");
    pulses_ov = 0;
    pulses_no = 0;
    for (int k = 6; k >= 0; k--) begin
      step(32'b0110110 >> k & 1, 1'b1, "overlap");
      pulses_ov += out_ov;
      pulses_no += out_no;
    end
    check("overlap_pulses", pulses_ov, 32'd2);
    check("nooverlap_pulses", pulses_no, 32'd1);

    step(1'b0, 1'b0, "rst3");
    send(32'b101011100110, 12, "nearmiss");
    check("nearmiss_last", {31'b0, out_ov}, 32'd1);

    step(1'b0, 1'b0, "rst4");
    send(32'b011, 3, "midrst_pre");
    step(1'b0, 1'b0, "midrst");
    step(1'b0, 1'b1, "midrst_post");
    check("midrst_nopulse", {31'b0, out_ov}, 32'd0);
    send(32'b110, 3, "midrst_tail");
    send(32'b0110, 4, "midrst_match");

    for (int m = 0; m < 5; m++) send(32'b0110, 4, "sat");

    for (int k = 0; k < 600; k++) begin
      logic b, r;
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 49) != 0);
      step(b, r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detect_sequence_0110.md
# detect_sequence_0110

Serial pattern detector that watches a 1-bit input stream and flags every occurrence of the bit sequence 0-1-1-0, with overlapping matches counted by default. It is a small Moore state machine used as a protocol/marker detector on a serial data line. It has a single-cycle registered match pulse and an optional saturating match counter.

## Interface
- OVERLAP, 1, 1: a match's trailing 0 may start the next match; 0: detector restarts from idle after each match
- CNT_W, 8, width of optional match counter (≥1)
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- in  input  1  serial data bit, one bit sampled per clk rising edge
- out  output  1  registered match pulse, high one cycle per detected 0110
- match_cnt  output  CNT_W  matches since reset (present only with DETECT_SEQUENCE_COUNT_EN)

## Operation
- States: IDLE (no prefix), S0 ("0"), S01 ("01"), S011 ("011"), DET (full "0110" just seen); 3-bit encoding, enumerated.
- IDLE: in=0 → S0; in=1 → IDLE.
- S0: in=1 → S01; in=0 → S0.
- S01: in=1 → S011; in=0 → S0.
- S011: in=0 → DET; in=1 → IDLE.
- DET, OVERLAP=1: in=0 → S0; in=1 → S01 (trailing 0 reused as prefix).
- DET, OVERLAP=0: in=0 → S0; in=1 → IDLE (no bit of a match reused).
- out = 1 iff state == DET (Moore, decoded from state register, no combinational path from in).
- in of X/Z outside reset is illegal; synthesized logic treats any non-1 value as 0.

## Timing
- Reset (reset=0 at a rising edge): state ← IDLE, out ← 0, match_cnt ← 0. Reset takes priority over any in value; bits sampled during reset are discarded.
- First bit after reset is the one sampled on the first edge with reset=1.
- Latency: out rises in the cycle following the edge that samples the final 0; high for exactly one cycle unless the next pattern completes immediately (impossible for 0110; minimum spacing between pulses is 3 cycles with OVERLAP=1, 4 with OVERLAP=0).
- Reset asserted mid-pattern: partial prefix discarded, no pulse; a pending DET is cleared to out=0 on that edge.
- match_cnt increments on the same edge state enters DET; saturates at 2^CNT_W−1 (no wrap).

## Configuration
- DETECT_SEQUENCE_COUNT_EN defined: match_cnt port and saturating counter present.
- Not defined: match_cnt port and counter logic absent; out behaviour identical.

## Structure
- Shared package detect_sequence_pkg: state enum type (IDLE, S0, S01, S011, DET), STATE_W=3, pattern constant 4'b0110 for benches.
- Single module; counter is small enough to stay inline, optional sub-module sat_counter (parameter CNT_W, inc, clear) if reused elsewhere.

## Test plan
- Reset: hold reset=0 for 2 cycles with in toggling → out=0, match_cnt=0, no pulse after release until a full 0110 arrives.
- Basic: in = 0,1,1,0 → out=1 for exactly one cycle, the cycle after the 4th bit; match_cnt=1.
- Overlap (OVERLAP=1): in = 0,1,1,0,1,1,0 → two pulses, after bits 4 and 7; match_cnt=2.
- No overlap (OVERLAP=0): same stream 0,1,1,0,1,1,0 → one pulse after bit 4; match_cnt=1.
- Near-misses: in = 1,0,1,0,1,1,1,0,0,1,1,0 → single pulse after bit 12 only; 0111 and 010 prefixes produce no pulse.
- Mid-pattern reset: in = 0,1,1 then reset=0 one cycle, then in=0 → no pulse; subsequent 0,1,1,0 → one pulse; saturation: CNT_W=2, five matches → match_cnt holds 3.
